// File: rtl/move_pkg.sv
// Shared move codes, grid limits and controller state encoding for the player movement path.
package move_pkg;

  localparam logic [2:0] MOVE_NONE  = 3'b000;
  localparam logic [2:0] MOVE_UP    = 3'b001;
  localparam logic [2:0] MOVE_LEFT  = 3'b010;
  localparam logic [2:0] MOVE_DOWN  = 3'b011;
  localparam logic [2:0] MOVE_RIGHT = 3'b100;

  localparam int unsigned GRID_COLS = 20;
  localparam int unsigned GRID_ROWS = 15;

  // Wide enough for the 4 steps/s cooldown at 50 MHz.
  localparam int unsigned CntW = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    COOL
  } state_e;

endpackage

// File: rtl/move_rate_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module move_rate_timer
  import move_pkg::*;
#(
  parameter int unsigned Width = CntW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/player_move_ctrl.sv
// Turns held direction keys into rate-limited single-step requests to the collision checker
// and owns the player position registers.
module player_move_ctrl
  import move_pkg::*;
#(
  parameter int unsigned START_X     = 1,
  parameter int unsigned START_Y     = 2,
  parameter int unsigned COLS        = GRID_COLS,
  parameter int unsigned ROWS        = GRID_ROWS,
  parameter int unsigned SETTLE      = 2,
  parameter int unsigned MOVE_PERIOD = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic [2:0] map,
  input  logic [5:0] new_x_pos,
  input  logic [5:0] new_y_pos,
  output logic [2:0] move,
  output logic [5:0] current_x_pos,
  output logic [5:0] current_y_pos,
  output logic       moved,
  output logic       blocked,
  output logic       busy
);

  localparam logic [5:0]      StartX   = 6'(START_X);
  localparam logic [5:0]      StartY   = 6'(START_Y);
  localparam logic [CntW-1:0] SettleLd = CntW'(SETTLE - 1);
  localparam logic [CntW-1:0] CoolLd   = CntW'(MOVE_PERIOD - 1);

  state_e          state_q, state_d;
  logic [2:0]      dir_q, dir_d;
  logic [5:0]      x_q, x_d;
  logic [5:0]      y_q, y_d;
  logic            moved_q, moved_d;
  logic            blocked_q, blocked_d;
  logic [2:0]      map_q;
  logic            map_vld_q;

  logic [2:0]      key_dir;
  logic            map_chg;
  logic            in_bounds;
  logic            changed;
  logic            tmr_clear;
  logic            tmr_load;
  logic [CntW-1:0] tmr_val;
  logic            tmr_done;

  move_rate_timer #(
    .Width (CntW)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .clear_i    (tmr_clear),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    if (key_up) begin
      key_dir = MOVE_UP;
    end else if (key_down) begin
      key_dir = MOVE_DOWN;
    end else if (key_left) begin
      key_dir = MOVE_LEFT;
    end else if (key_right) begin
      key_dir = MOVE_RIGHT;
    end else begin
      key_dir = MOVE_NONE;
    end
  end

  // map_q holds no valid history until the first clock after reset.
  assign map_chg   = map_vld_q && (map != map_q);
  assign in_bounds = (32'(new_x_pos) < COLS) && (32'(new_y_pos) < ROWS);
  assign changed   = (new_x_pos != x_q) || (new_y_pos != y_q);

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    x_d       = x_q;
    y_d       = y_q;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = SettleLd;
    if (map_chg) begin
      state_d   = IDLE;
      x_d       = StartX;
      y_d       = StartY;
      tmr_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (key_dir != MOVE_NONE) begin
            dir_d    = key_dir;
            tmr_load = 1'b1;
            tmr_val  = SettleLd;
            state_d  = REQ;
          end
        end
        REQ: begin
          if (tmr_done) begin
            if (in_bounds) begin
              x_d = new_x_pos;
              y_d = new_y_pos;
            end
            moved_d   = in_bounds && changed;
            blocked_d = !(in_bounds && changed);
            tmr_load  = 1'b1;
            tmr_val   = CoolLd;
            state_d   = COOL;
          end
        end
        COOL: begin
          if (tmr_done) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= MOVE_NONE;
      x_q       <= StartX;
      y_q       <= StartY;
      moved_q   <= 1'b0;
      blocked_q <= 1'b0;
      map_q     <= 3'b000;
      map_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      x_q       <= x_d;
      y_q       <= y_d;
      moved_q   <= moved_d;
      blocked_q <= blocked_d;
      map_q     <= map;
      map_vld_q <= 1'b1;
    end
  end

  assign move          = (state_q == REQ) ? dir_q : MOVE_NONE;
  assign current_x_pos = x_q;
  assign current_y_pos = y_q;
  assign moved         = moved_q;
  assign blocked       = blocked_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: walled-grid checker model plus a scoreboard of step outcomes.
module tb_player_move_ctrl;

  localparam int unsigned Settle     = 2;
  localparam int unsigned MovePeriod = 4;

  logic       clk;
  logic       reset;
  logic       key_up, key_down, key_left, key_right;
  logic [2:0] map;
  logic [5:0] new_x_pos, new_y_pos;
  logic [2:0] move;
  logic [5:0] current_x_pos, current_y_pos;
  logic       moved, blocked, busy;

  typedef struct packed {
    logic       moved;
    logic [5:0] x;
    logic [5:0] y;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   force_oob = 1'b0;
  int   mx = 1;
  int   my = 2;

  player_move_ctrl #(
    .START_X     (1),
    .START_Y     (2),
    .COLS        (20),
    .ROWS        (15),
    .SETTLE      (Settle),
    .MOVE_PERIOD (MovePeriod)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_up        (key_up),
    .key_down      (key_down),
    .key_left      (key_left),
    .key_right     (key_right),
    .map           (map),
    .new_x_pos     (new_x_pos),
    .new_y_pos     (new_y_pos),
    .move          (move),
    .current_x_pos (current_x_pos),
    .current_y_pos (current_y_pos),
    .moved         (moved),
    .blocked       (blocked),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Collision checker model: walls on rows 0/14 and columns 0/19.
  logic [5:0] tx, ty;
  always_comb begin
    tx = current_x_pos;
    ty = current_y_pos;
    case (move)
      3'd1:    ty = current_y_pos - 6'd1;
      3'd2:    tx = current_x_pos - 6'd1;
      3'd3:    ty = current_y_pos + 6'd1;
      3'd4:    tx = current_x_pos + 6'd1;
      default: ;
    endcase
    if (force_oob) begin
      new_x_pos = 6'd0;
      new_y_pos = 6'd63;
    end else if (tx == 6'd0 || tx == 6'd19 || ty == 6'd0 || ty == 6'd14) begin
      new_x_pos = current_x_pos;
      new_y_pos = current_y_pos;
    end else begin
      new_x_pos = tx;
      new_y_pos = ty;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (moved || blocked)) begin
      if (sb_q.size() == 0) begin
        check_eq("pulse_unexpected", 32'({moved, blocked}), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("pulse_moved", 32'(moved), 32'(mon_e.moved));
        check_eq("pulse_blocked", 32'(blocked), 32'(!mon_e.moved));
        check_eq("pulse_x", 32'(current_x_pos), 32'(mon_e.x));
        check_eq("pulse_y", 32'(current_y_pos), 32'(mon_e.y));
      end
    end
  end

  task automatic check_idle_start();
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_move", 32'(move), 32'd0);
    check_eq("idle_x", 32'(current_x_pos), 32'd1);
    check_eq("idle_y", 32'(current_y_pos), 32'd2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check_idle_start();
    check_eq("rst_moved", 32'(moved), 32'd0);
    check_eq("rst_blocked", 32'(blocked), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mx = 1;
    my = 2;
  endtask

  // Called at the negedge of an IDLE cycle; returns at the negedge of the next IDLE cycle.
  task automatic attempt(input logic [3:0] k, input logic [2:0] code, input bit oob);
    int   px, py;
    exp_t e;
    check_eq("att_idle", 32'(busy), 32'd0);
    px = mx;
    py = my;
    case (code)
      3'd1:    py = my - 1;
      3'd2:    px = mx - 1;
      3'd3:    py = my + 1;
      3'd4:    px = mx + 1;
      default: ;
    endcase
    if (oob || px == 0 || px == 19 || py == 0 || py == 14) begin
      e = '{moved: 1'b0, x: 6'(mx), y: 6'(my)};
    end else begin
      e = '{moved: 1'b1, x: 6'(px), y: 6'(py)};
      mx = px;
      my = py;
    end
    sb_q.push_back(e);
    force_oob = oob;
    {key_up, key_down, key_left, key_right} = k;
    @(negedge clk);
    {key_up, key_down, key_left, key_right} = 4'b0000;
    for (int i = 0; i < int'(Settle); i++) begin
      check_eq("att_move", 32'(move), 32'(code));
      check_eq("att_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check_eq("att_cool_move", 32'(move), 32'd0);
    force_oob = 1'b0;
    repeat (MovePeriod) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    key_up    = 1'b0;
    key_down  = 1'b0;
    key_left  = 1'b0;
    key_right = 1'b0;
    map       = 3'd0;

    // Held right key: two attempts 7 cycles apart.
    do_reset();
    key_right = 1'b1;
    sb_q.push_back('{moved: 1'b1, x: 6'd2, y: 6'd2});
    sb_q.push_back('{moved: 1'b1, x: 6'd3, y: 6'd2});
    @(negedge clk);
    check_eq("held_move_c1", 32'(move), 32'd4);
    @(negedge clk);
    check_eq("held_move_c2", 32'(move), 32'd4);
    @(negedge clk);
    check_eq("held_move_c3", 32'(move), 32'd0);
    check_eq("held_busy_c3", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    check_eq("held_idle_c7", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("held_move_c8", 32'(move), 32'd4);
    key_right = 1'b0;
    @(negedge clk);
    check_eq("held_move_c9", 32'(move), 32'd4);
    repeat (5) @(negedge clk);
    mx = 3;
    my = 2;

    // Left into the column-0 wall is blocked.
    do_reset();
    attempt(4'b0010, 3'd2, 1'b0);
    repeat (4) attempt(4'b0001, 3'd4, 1'b0);
    // Priority: up over right, then up into the row-0 wall.
    attempt(4'b1001, 3'd1, 1'b0);
    attempt(4'b1000, 3'd1, 1'b0);
    // Out-of-range checker result is rejected.
    attempt(4'b0001, 3'd4, 1'b1);
    attempt(4'b0111, 3'd3, 1'b0);
    attempt(4'b0011, 3'd2, 1'b0);
    check_eq("pos_x_before_map", 32'(current_x_pos), 32'd4);

    // Map change landing on the commit cycle wins over the commit.
    key_right = 1'b1;
    @(negedge clk);
    key_right = 1'b0;
    check_eq("map_move_c1", 32'(move), 32'd4);
    @(negedge clk);
    check_eq("map_move_c2", 32'(move), 32'd4);
    map = 3'd2;
    @(negedge clk);
    check_idle_start();
    repeat (4) @(negedge clk);
    mx = 1;
    my = 2;

    // Walk to (7,5), then reset asynchronously during cooldown.
    repeat (6) attempt(4'b0001, 3'd4, 1'b0);
    repeat (3) attempt(4'b0100, 3'd3, 1'b0);
    check_eq("pos_x_75", 32'(current_x_pos), 32'd7);
    check_eq("pos_y_75", 32'(current_y_pos), 32'd5);
    key_right = 1'b1;
    sb_q.push_back('{moved: 1'b1, x: 6'd8, y: 6'd5});
    @(negedge clk);
    key_right = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("cool_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_idle_start();
    check_eq("async_moved", 32'(moved), 32'd0);
    check_eq("async_blocked", 32'(blocked), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mx = 1;
    my = 2;
    attempt(4'b0001, 3'd4, 1'b0);
    repeat (2) @(negedge clk);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
- Sequential stage directly upstream of the combinational collision checker.
- Converts held direction keys into rate-limited single-step move requests and owns the player position registers.
- Drives the current position and move code into the checker, then latches the checker's resolved position back into its own registers.
- Its position outputs feed the checker and the renderer.

Parameters:
- START_X, 1: column loaded on reset and on map change.
- START_Y, 2: row loaded on reset and on map change.
- COLS, 20: grid width; a legal x satisfies x < COLS.
- ROWS, 15: grid height; a legal y satisfies y < ROWS.
- SETTLE, 2: cycles the move code is held before the checker result is sampled (≥1).
- MOVE_PERIOD, 12500000: cooldown cycles after each step attempt (≥1); the default gives 4 steps/s at 50 MHz.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- key_up  in  1  active-high level, already synchronised.
- key_down  in  1  active-high level.
- key_left  in  1  active-high level.
- key_right  in  1  active-high level.
- map  in  3  selected map index; only bits [1:0] are meaningful downstream.
- new_x_pos  in  6  resolved x returned by the collision checker.
- new_y_pos  in  6  resolved y returned by the collision checker.
- move  out  3  move code to the checker.
- current_x_pos  out  6  registered player x.
- current_y_pos  out  6  registered player y.
- moved  out  1  one-cycle pulse: step committed and position changed.
- blocked  out  1  one-cycle pulse: step attempted, position unchanged.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clocking: one clock, clk. reset is asynchronous, active-high, and applies in any state including mid-step.
- Reset values: state=IDLE, move=3'b000, current_x_pos=START_X, current_y_pos=START_Y, moved=0, blocked=0, busy=0, counters=0, map_q=map sampled at the first clock after reset deassertion.
- Move codes: 000 none, 001 up, 010 left, 011 down, 100 right. Codes 101–111 are never driven.
- Key priority when several keys are high: up > down > left > right.
- IDLE:
  - move=000.
  - If any key is high: latch the encoded direction into dir_q, clear cnt, go to REQ.
  - Keys are sampled only in IDLE.
- REQ:
  - move=dir_q; cnt increments each cycle.
  - In the cycle where cnt==SETTLE-1, register new_x_pos/new_y_pos into the position registers, clear cnt, go to COOL.
  - The sample is accepted only if new_x_pos<COLS and new_y_pos<ROWS; otherwise the position is kept.
  - In the following cycle, pulse moved if the position changed, else pulse blocked. Exactly one of the two pulses per attempt.
- COOL:
  - move=000.
  - Count MOVE_PERIOD cycles, then go to IDLE.
- Step latency and cadence:
  - The key is seen in IDLE at cycle n.
  - move is valid for cycles n+1..n+SETTLE; the position updates at the end of cycle n+SETTLE.
  - The moved/blocked pulse occurs in cycle n+SETTLE+1.
  - A held key yields one attempt every 1+SETTLE+MOVE_PERIOD cycles.
- Map change:
  - map_q registers map every cycle.
  - If map != map_q in any state: go to IDLE next cycle, set move=000, load the position to START, clear cnt, suppress moved/blocked.
  - Map change has priority over a same-cycle REQ commit.
- Arithmetic: ±1 arithmetic is done by the checker, not here. A 6-bit wrap such as 0-1=63 is caught by the bounds check and rejected.
- Keys released during REQ/COOL have no effect; the attempt completes.

Decomposition:
- Package move_pkg holds:
  - the MOVE_NONE/UP/LEFT/DOWN/RIGHT 3-bit constants;
  - the GRID_COLS=20 and GRID_ROWS=15 constants;
  - the state encoding IDLE/REQ/COOL.
- One sub-module, move_rate_timer: a loadable down-counter with a done pulse, used for both the SETTLE and MOVE_PERIOD counts.
- The priority encoder stays inline.

Test Plan:
Bench setup: SETTLE=2, MOVE_PERIOD=4, and a checker model with walls on rows 0 and 14 and columns 0 and 19.
1. Reset, then hold key_right from cycle 0 → move=100 in cycles 1–2, position (2,2) at cycle 3 with moved=1; next attempt at cycle 7, giving (3,2).
2. From (1,2), pulse key_left once → move=010 for 2 cycles, checker returns (1,2), blocked=1 at cycle 3, moved=0, position unchanged.
3. key_up and key_right high together → move=001; from (5,2) the result is (5,1).
4. Checker model forced to return (0,63) → out-of-bounds sample rejected, position held, blocked pulses.
5. map changes 0→2 during REQ → the next cycle is IDLE with move=000, position (1,2), no pulses.
6. reset asserted asynchronously mid-COOL at position (7,5) → outputs return to reset values immediately without a clock edge.
